// File: rtl/vga_timing_pkg.sv
// Shared timing constants, colour codes and payload types for the 800x600@72 VGA raster.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 11;
  localparam int unsigned RGB_W = 3;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned H_FRONT  = 56;
  localparam int unsigned H_SYNC   = 120;
  localparam int unsigned H_BACK   = 64;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_ACTIVE = 600;
  localparam int unsigned V_FRONT  = 37;
  localparam int unsigned V_SYNC   = 6;
  localparam int unsigned V_BACK   = 23;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Inclusive sync windows in counter coordinates
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Test-pattern bar geometry
  localparam int unsigned BAR_W    = 100;
  localparam int unsigned NUM_BARS = 8;

  typedef logic [RGB_W-1:0] rgb_t;

  // {R,G,B} colour codes shared with game_engine
  localparam rgb_t BLACK  = 3'b000;
  localparam rgb_t RED    = 3'b100;
  localparam rgb_t YELLOW = 3'b110;
  localparam rgb_t BLUE   = 3'b001;
  localparam rgb_t WHITE  = 3'b111;

  // Raw per-pixel timing flags carried through the delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } timing_t;

  // Bar index for a horizontal position; positions past the last bar saturate
  function automatic rgb_t bar_colour(input logic [CNT_W-1:0] h);
    rgb_t bar;
    bar = BLACK;
    for (int unsigned i = 1; i < NUM_BARS; i++) begin
      if (h >= CNT_W'(i * BAR_W)) bar = RGB_W'(i);
    end
    return bar;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line with asynchronous clear to a configurable value.
module vga_delay_line #(
  parameter int unsigned      DEPTH       = 1,
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift data one stage per clock; reset clears every stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RESET_VALUE;
    end else begin
      stage[0] <= data;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_controller.sv
// 800x600@72 VGA raster generator: counters, frame pulse, and pin-aligned sync/colour.
// Optional build macro VGA_TEST_PATTERN_EN adds TEST_MODE and an eight-bar colour source.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter bit          SYNC_POL      = 1'b1,
  parameter int unsigned PIXEL_LATENCY = 1
) (
  input  logic             VGA_CLOCK,
  input  logic             RESET_N,
  input  logic [RGB_W-1:0] PIXEL,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             TEST_MODE,
`endif
  output logic [CNT_W-1:0] PIXEL_H,
  output logic [CNT_W-1:0] PIXEL_V,
  output logic             FRAME_START,
  output logic             VGA_HSYNC,
  output logic             VGA_VSYNC,
  output logic             VGA_R,
  output logic             VGA_G,
  output logic             VGA_B
);

  logic [CNT_W-1:0] h_next_c;
  logic [CNT_W-1:0] v_next_c;
  timing_t          raw_c;
  timing_t          timing_d;
  rgb_t             colour_c;

  // Next raster position: H every cycle, V on the H wrap
  always_comb begin
    h_next_c = PIXEL_H + CNT_W'(1);
    v_next_c = PIXEL_V;
    if (PIXEL_H == CNT_W'(H_TOTAL - 1)) begin
      h_next_c = '0;
      v_next_c = (PIXEL_V == CNT_W'(V_TOTAL - 1)) ? '0 : PIXEL_V + CNT_W'(1);
    end
  end

  // Raster counters and frame pulse; reset parks on the last position so the first edge lands on (0,0)
  always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      PIXEL_H     <= CNT_W'(H_TOTAL - 1);
      PIXEL_V     <= CNT_W'(V_TOTAL - 1);
      FRAME_START <= 1'b0;
    end else begin
      PIXEL_H     <= h_next_c;
      PIXEL_V     <= v_next_c;
      FRAME_START <= (h_next_c == '0) && (v_next_c == '0);
    end
  end

  // Raw timing flags for the coordinate currently on PIXEL_H/PIXEL_V
  always_comb begin
    raw_c        = '0;
    raw_c.hs     = (PIXEL_H >= CNT_W'(H_SYNC_START)) && (PIXEL_H <= CNT_W'(H_SYNC_END));
    raw_c.vs     = (PIXEL_V >= CNT_W'(V_SYNC_START)) && (PIXEL_V <= CNT_W'(V_SYNC_END));
    raw_c.active = (PIXEL_H < CNT_W'(H_ACTIVE)) && (PIXEL_V < CNT_W'(V_ACTIVE));
  end

  // Match the flags to the game_engine pixel latency
  vga_delay_line #(
    .DEPTH      (PIXEL_LATENCY),
    .WIDTH      ($bits(timing_t)),
    .RESET_VALUE('0)
  ) u_timing_dly (
    .clk    (VGA_CLOCK),
    .rst_n  (RESET_N),
    .data   (raw_c),
    .delayed(timing_d)
  );

`ifdef VGA_TEST_PATTERN_EN
  logic [CNT_W:0] pattern_d;

  // Carry {TEST_MODE, H} with the same latency so the source switches on a pixel boundary
  vga_delay_line #(
    .DEPTH      (PIXEL_LATENCY),
    .WIDTH      (CNT_W + 1),
    .RESET_VALUE('0)
  ) u_pattern_dly (
    .clk    (VGA_CLOCK),
    .rst_n  (RESET_N),
    .data   ({TEST_MODE, PIXEL_H}),
    .delayed(pattern_d)
  );

  assign colour_c = pattern_d[CNT_W] ? bar_colour(pattern_d[CNT_W-1:0]) : PIXEL;
`else
  assign colour_c = PIXEL;
`endif

  // Pin register: sync polarity applied, colour forced black outside the active area
  always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      VGA_HSYNC               <= ~SYNC_POL;
      VGA_VSYNC               <= ~SYNC_POL;
      {VGA_R, VGA_G, VGA_B}   <= BLACK;
    end else begin
      VGA_HSYNC               <= timing_d.hs ^ ~SYNC_POL;
      VGA_VSYNC               <= timing_d.vs ^ ~SYNC_POL;
      {VGA_R, VGA_G, VGA_B}   <= timing_d.active ? colour_c : BLACK;
    end
  end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Self-checking bench for vga_timing_controller: raster model with pin scoreboard plus hand-computed spot checks.
`timescale 1ns/1ps
module tb_vga_timing_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  pixel = 3'b000;
  logic        test_mode = 1'b0;
  logic [10:0] pixel_h, pixel_v;
  logic        frame_start, hsync, vsync, r, g, b;

  always #10 clk = ~clk;

  vga_timing_controller dut (
    .VGA_CLOCK  (clk),
    .RESET_N    (rst_n),
    .PIXEL      (pixel),
`ifdef VGA_TEST_PATTERN_EN
    .TEST_MODE  (test_mode),
`endif
    .PIXEL_H    (pixel_h),
    .PIXEL_V    (pixel_v),
    .FRAME_START(frame_start),
    .VGA_HSYNC  (hsync),
    .VGA_VSYNC  (vsync),
    .VGA_R      (r),
    .VGA_G      (g),
    .VGA_B      (b)
  );

  // game_engine stand-in: registered low 3 bits of H inside the visible area, white elsewhere
  always @(posedge clk)
    pixel <= (pixel_h < 11'd800 && pixel_v < 11'd600) ? pixel_h[2:0] : 3'b111;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
  } pins_t;

  typedef struct {
    int         cyc;
    int         h;
    int         v;
    logic       hs;
    logic       fs;
    logic [2:0] rgb;
  } spot_t;

  pins_t       sb[$];
  int          mh, mv;
  logic        fs_exp;
  int          errors = 0;
  int          checks = 0;
  logic        jump_req = 1'b0;
  logic [10:0] jh, jv;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic pins_t expect_from(input int h, input int v, input logic tm);
    pins_t e;
    e.hs = (h >= 856 && h <= 975);
    e.vs = (v >= 637 && v <= 642);
    if (h < 800 && v < 600) e.rgb = tm ? 3'(h / 100) : 3'(h % 8);
    else                    e.rgb = 3'b000;
    return e;
  endfunction

  // Model state after reset release: pipe holds cleared stage then the (1039,665) flags
  task automatic reset_model();
    sb.delete();
    sb.push_back('0);
    sb.push_back(expect_from(1039, 665, 1'b0));
    mh = 0;
    mv = 0;
    fs_exp = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_h"},   int'(pixel_h), 1039);
    check({tag, "_v"},   int'(pixel_v), 665);
    check({tag, "_fs"},  int'(frame_start), 0);
    check({tag, "_hs"},  int'(hsync), 0);
    check({tag, "_vs"},  int'(vsync), 0);
    check({tag, "_rgb"}, int'({r, g, b}), 0);
  endtask

  // One cycle: compare counters and pins at negedge, then push the expectation for this coordinate
  task automatic step();
    pins_t e;
    logic  jumped;
    jumped = 1'b0;
    @(negedge clk);
    check("pixel_h", int'(pixel_h), mh);
    check("pixel_v", int'(pixel_v), mv);
    check("frame_start", int'(frame_start), int'(fs_exp));
    e = sb.pop_front();
    check("hsync", int'(hsync), int'(e.hs));
    check("vsync", int'(vsync), int'(e.vs));
    check("rgb", int'({r, g, b}), int'(e.rgb));
    if (jump_req) begin
      force dut.PIXEL_H = jh;
      force dut.PIXEL_V = jv;
      mh = int'(jh);
      mv = int'(jv);
      jump_req = 1'b0;
      jumped = 1'b1;
    end
    sb.push_back(expect_from(mh, mv, test_mode));
    if (mh == 1039) begin
      mh = 0;
      mv = (mv == 665) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    fs_exp = (mh == 0 && mv == 0);
    if (jumped) begin
      @(posedge clk);
      #1;
      jh = 11'(mh);
      jv = 11'(mv);
      force dut.PIXEL_H = jh;
      force dut.PIXEL_V = jv;
      #1;
      release dut.PIXEL_H;
      release dut.PIXEL_V;
    end
  endtask

  task automatic jump(input int h, input int v);
    jh = 11'(h);
    jv = 11'(v);
    jump_req = 1'b1;
    step();
  endtask

  spot_t spots[14];
  int    first_hi, hi_cnt, nz_cnt, fs_at, fs_cnt;

  initial begin
    spots[0]  = '{0,    0,    0, 1'b0, 1'b1, 3'b000};
    spots[1]  = '{1,    1,    0, 1'b0, 1'b0, 3'b000};
    spots[2]  = '{2,    2,    0, 1'b0, 1'b0, 3'b000};
    spots[3]  = '{7,    7,    0, 1'b0, 1'b0, 3'b101};
    spots[4]  = '{801,  801,  0, 1'b0, 1'b0, 3'b111};
    spots[5]  = '{802,  802,  0, 1'b0, 1'b0, 3'b000};
    spots[6]  = '{857,  857,  0, 1'b0, 1'b0, 3'b000};
    spots[7]  = '{858,  858,  0, 1'b1, 1'b0, 3'b000};
    spots[8]  = '{977,  977,  0, 1'b1, 1'b0, 3'b000};
    spots[9]  = '{978,  978,  0, 1'b0, 1'b0, 3'b000};
    spots[10] = '{1039, 1039, 0, 1'b0, 1'b0, 3'b000};
    spots[11] = '{1040, 0,    1, 1'b0, 1'b0, 3'b000};
    spots[12] = '{1049, 9,    1, 1'b0, 1'b0, 3'b111};
    spots[13] = '{1900, 860,  1, 1'b1, 1'b0, 3'b000};

    // Reset held for five cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_reset("reset");
    end
    rst_n = 1'b1;
    reset_model();

    // First two lines with hand-computed spot values
    for (int n = 0; n < 2100; n++) begin
      step();
      for (int i = 0; i < 14; i++) begin
        if (spots[i].cyc == n) begin
          check("spot_h",   int'(pixel_h), spots[i].h);
          check("spot_v",   int'(pixel_v), spots[i].v);
          check("spot_hs",  int'(hsync), int'(spots[i].hs));
          check("spot_fs",  int'(frame_start), int'(spots[i].fs));
          check("spot_rgb", int'({r, g, b}), int'(spots[i].rgb));
        end
      end
    end

    // Vertical blanking: colour stays black although PIXEL is white
    jump(1039, 599);
    nz_cnt = 0;
    for (int m = 0; m < 2080; m++) begin
      step();
      if (m >= 2 && {r, g, b} != 3'b000) nz_cnt++;
    end
    check("vblank_rgb_nonzero", nz_cnt, 0);

    // Vertical sync window
    jump(1039, 636);
    first_hi = -1;
    hi_cnt = 0;
    for (int m = 0; m < 8 * 1040; m++) begin
      step();
      if (vsync) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = m;
      end
    end
    check("vsync_first", first_hi, 2);
    check("vsync_len", hi_cnt, 6240);

    // Frame wrap
    jump(1030, 665);
    fs_at = -1;
    fs_cnt = 0;
    for (int m = 0; m < 20; m++) begin
      step();
      if (frame_start) begin
        fs_cnt++;
        fs_at = m;
      end
    end
    check("wrap_fs_at", fs_at, 9);
    check("wrap_fs_cnt", fs_cnt, 1);

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars on line 10, source switched back mid-way through line 11
    test_mode = 1'b1;
    jump(1039, 9);
    for (int m = 0; m < 2080; m++) begin
      step();
      if (m == 2)    check("bar0_rgb", int'({r, g, b}), 0);
      if (m == 152)  check("bar1_rgb", int'({r, g, b}), 1);
      if (m == 352)  check("bar3_rgb", int'({r, g, b}), 3);
      if (m == 801)  check("bar7_rgb", int'({r, g, b}), 7);
      if (m == 802)  check("bar_blank_rgb", int'({r, g, b}), 0);
      if (m == 1040 + 450) test_mode = 1'b0;
    end
    test_mode = 1'b0;
`endif

    // Mid-frame reset at (500,300)
    jump(1039, 299);
    for (int m = 0; m < 501; m++) step();
    check("pre_reset_h", int'(pixel_h), 500);
    check("pre_reset_v", int'(pixel_v), 300);
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    @(negedge clk);
    check_reset("held_reset");
    rst_n = 1'b1;
    reset_model();
    step();
    check("restart_h", int'(pixel_h), 0);
    check("restart_v", int'(pixel_v), 0);
    check("restart_fs", int'(frame_start), 1);
    for (int m = 0; m < 1045; m++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
